wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  asynchronous active-high reset.
REQ-002 The block SHALL have these issue and hazard ports: issue_valid  in  1  decode issues an instruction writing issue_rd; issue_rd  in  5  destination register of issued instruction.
REQ-003 The block SHALL have these hazard-check ports: rs1_sel  in  5  decode source 1; rs2_sel  in  5  decode source 2; hazard  out  1  a source is pending writeback.
REQ-004 The block SHALL have these ALU writeback ports: alu_valid  in  1; alu_ready  out  1; alu_rd  in  5; alu_data  in  32.
REQ-005 The block SHALL have these LSU writeback ports: lsu_valid  in  1; lsu_ready  out  1; lsu_rd  in  5; lsu_data  in  32.
REQ-006 The block SHALL have these register-file write-port outputs: rd_w  out  1  write enable; rd_sel  out  5  write index; rd_in  out  32  write data.
REQ-007 The block SHALL have this status output: busy  out  32  pending-write mask, one bit per register.

Function
REQ-008 Arbitration SHALL be round-robin between ALU and LSU using a last_grant flag.
- One valid source: that source is granted.
- Both valid: the source not equal to last_grant is granted.
REQ-009 Each ready output SHALL be a combinational function of both valid inputs and last_grant.
- A ready output is 1 only when its source is granted in that cycle.
- At most one ready is 1 per cycle.
REQ-010 A transfer SHALL occur when valid && ready for a source; on a transfer, last_grant takes that source at the next posedge.
REQ-011 A source SHALL hold rd and data stable while valid && !ready; the block does not buffer ungranted requests.
REQ-012 On a transfer with rd != 0, rd_w/rd_sel/rd_in SHALL present the transfer at the next posedge (latency 1 cycle).
REQ-013 rd_w SHALL be 1 for exactly one cycle per such transfer and 0 in every cycle without one; rd_sel and rd_in hold their last values while rd_w = 0.
REQ-014 A transfer with rd = 0 SHALL be accepted (ready asserted, last_grant updated) and SHALL leave rd_w = 0 and busy unchanged.
REQ-015 On posedge with issue_valid && issue_rd != 0, busy[issue_rd] SHALL be set.
REQ-016 On posedge with a transfer to rd != 0, busy[rd] SHALL be cleared.
REQ-017 When set and clear target the same register in one cycle, set SHALL win and busy stays 1.
REQ-018 Issuing to an already-busy register SHALL leave it busy; there is no per-register counting.
REQ-019 busy[0] SHALL be 0 at all times.
REQ-020 hazard SHALL be combinational: (rs1_sel != 0 && busy[rs1_sel]) || (rs2_sel != 0 && busy[rs2_sel]).

Reset
REQ-021 While rst = 1, asynchronously:
- rd_w = 0, rd_sel = 0, rd_in = 0;
- busy = 0;
- last_grant = LSU, so the ALU wins the first contested cycle;
- alu_ready = lsu_ready = 0.
REQ-022 A request pending when reset asserts SHALL be discarded.
- No write is produced after reset deasserts unless the request is presented again.

Configuration
REQ-023 With WB_EARLY_RELEASE_EN defined, a register whose clearing transfer occurs in the current cycle SHALL not contribute to hazard in that cycle.
- This permits same-cycle issue, since the register file writes on the falling edge.
REQ-024 Without WB_EARLY_RELEASE_EN, hazard SHALL depend on the registered busy mask only, per REQ-020.

Verification
REQ-025 Reset, then alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF for one cycle -> alu_ready=1 that cycle; next cycle rd_w=1, rd_sel=5, rd_in=0xDEADBEEF; the cycle after, rd_w=0.
REQ-026 Both sources valid continuously with distinct rd for 4 cycles after reset -> grants ALU, LSU, ALU, LSU; rd_w=1 on four consecutive cycles.
REQ-027 issue_valid=1, issue_rd=7, then rs1_sel=7 -> busy[7]=1, hazard=1.
- Then lsu transfer rd=7 -> busy[7]=0 the next cycle and hazard=0.
- With WB_EARLY_RELEASE_EN, hazard=0 already in the transfer cycle.
REQ-028 Same cycle: issue_rd=9 and ALU transfer rd=9 while busy[9]=1 -> busy[9] remains 1; rd_w=1, rd_sel=9 next cycle.
REQ-029 Transfer with rd=0 or issue_rd=0 -> ready asserted, rd_w stays 0, busy stays 0x00000000, hazard=0 for rs1_sel=0.
REQ-030 Assert rst while alu_valid=1 and busy=0x00000F00 -> busy=0, rd_w=0, ready=0 immediately; after release with alu_valid=0, no write occurs.

Source files
------------

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter
// Description : Writeback arbiter between the ALU and LSU result ports.
//               Grants round-robin on contention, drives a single registered
//               register-file write port, and keeps a per-register
//               pending-write (busy) mask used for decode hazard detection.
//               Optional feature macro: WB_EARLY_RELEASE_EN -- a register
//               being cleared by this cycle's transfer does not raise hazard.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  rs1_sel,
  input  logic [4:0]  rs2_sel,
  output logic        hazard,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  output logic        rd_w,
  output logic [4:0]  rd_sel,
  output logic [31:0] rd_in,
  output logic [31:0] busy
);

  localparam logic c_SRC_ALU = 1'b0;
  localparam logic c_SRC_LSU = 1'b1;

  logic        r_last_grant;
  logic [31:0] r_busy;
  logic        r_rd_w;
  logic [4:0]  r_rd_sel;
  logic [31:0] r_rd_in;

  logic        w_alu_grant;
  logic        w_lsu_grant;
  logic        w_xfer;
  logic [4:0]  w_xfer_rd;
  logic [31:0] w_xfer_data;
  logic        w_wr;
  logic [31:0] w_clr_mask;
  logic [31:0] w_set_mask;
  logic [31:0] w_busy_next;
  logic [31:0] w_busy_hz;

  // Round-robin grant: a contested cycle goes to the source that did not win
  // last; ready is forced low while reset is held.
  always_comb begin
    w_alu_grant = 1'b0;
    w_lsu_grant = 1'b0;
    if (!rst) begin
      if (alu_valid && lsu_valid) begin
        w_alu_grant = (r_last_grant == c_SRC_LSU);
        w_lsu_grant = (r_last_grant == c_SRC_ALU);
      end else begin
        w_alu_grant = alu_valid;
        w_lsu_grant = lsu_valid;
      end
    end
  end

  // Select the transferring source; grant already implies valid.
  always_comb begin
    w_xfer      = w_alu_grant || w_lsu_grant;
    w_xfer_rd   = 5'd0;
    w_xfer_data = 32'd0;
    if (w_alu_grant) begin
      w_xfer_rd   = alu_rd;
      w_xfer_data = alu_data;
    end else if (w_lsu_grant) begin
      w_xfer_rd   = lsu_rd;
      w_xfer_data = lsu_data;
    end
    // Writes to x0 are accepted but never reach the register file.
    w_wr = w_xfer && (w_xfer_rd != 5'd0);
  end

  // Busy-mask update: clear on writeback, set on issue; set wins on overlap.
  always_comb begin
    w_clr_mask  = w_wr ? (32'd1 << w_xfer_rd) : 32'd0;
    w_set_mask  = (issue_valid && (issue_rd != 5'd0)) ? (32'd1 << issue_rd) : 32'd0;
    w_busy_next = ((r_busy & ~w_clr_mask) | w_set_mask) & ~32'd1;
  end

  // Hazard check against the pending-write mask.
  always_comb begin
`ifdef WB_EARLY_RELEASE_EN
    // The register file writes on the falling edge, so a register being
    // written back this cycle is already safe to read.
    w_busy_hz = r_busy & ~w_clr_mask;
`else
    w_busy_hz = r_busy;
`endif
    hazard = ((rs1_sel != 5'd0) && w_busy_hz[rs1_sel]) ||
             ((rs2_sel != 5'd0) && w_busy_hz[rs2_sel]);
  end

  // Round-robin history: remembers the most recent source to transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= c_SRC_LSU;
    end else if (w_alu_grant) begin
      r_last_grant <= c_SRC_ALU;
    end else if (w_lsu_grant) begin
      r_last_grant <= c_SRC_LSU;
    end
  end

  // Register-file write port: one-cycle strobe, index/data hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_w   <= 1'b0;
      r_rd_sel <= 5'd0;
      r_rd_in  <= 32'd0;
    end else begin
      r_rd_w <= w_wr;
      if (w_wr) begin
        r_rd_sel <= w_xfer_rd;
        r_rd_in  <= w_xfer_data;
      end
    end
  end

  // Pending-write mask register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 32'd0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  assign alu_ready = w_alu_grant;
  assign lsu_ready = w_lsu_grant;
  assign rd_w      = r_rd_w;
  assign rd_sel    = r_rd_sel;
  assign rd_in     = r_rd_in;
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_arbiter
// Description : Self-checking bench for wb_arbiter: directed scenarios plus a
//               randomized run against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1_sel;
  logic [4:0]  rs2_sel;
  logic        hazard;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        rd_w;
  logic [4:0]  rd_sel;
  logic [31:0] rd_in;
  logic [31:0] busy;

  int checks;
  int failures;

  // Behavioural model state: last winner (0 = ALU, 1 = LSU), busy set, write port.
  int          m_last;
  bit          m_busy [32];
  bit          m_rd_w;
  int          m_rd_sel;
  logic [31:0] m_rd_in;

  wb_arbiter u_dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .rs1_sel     (rs1_sel),
    .rs2_sel     (rs2_sel),
    .hazard      (hazard),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .lsu_valid   (lsu_valid),
    .lsu_ready   (lsu_ready),
    .lsu_rd      (lsu_rd),
    .lsu_data    (lsu_data),
    .rd_w        (rd_w),
    .rd_sel      (rd_sel),
    .rd_in       (rd_in),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Which source wins this cycle: 0 = ALU, 1 = LSU, -1 = none.
  function automatic int model_winner();
    if (alu_valid && lsu_valid) return (m_last == 1) ? 0 : 1;
    if (alu_valid) return 0;
    if (lsu_valid) return 1;
    return -1;
  endfunction

  function automatic int model_xfer_rd();
    int w;
    w = model_winner();
    if (w == 0) return int'(alu_rd);
    if (w == 1) return int'(lsu_rd);
    return 0;
  endfunction

  function automatic bit model_hazard();
    int  r1;
    int  r2;
    int  clr;
    bit  b1;
    bit  b2;
    r1  = int'(rs1_sel);
    r2  = int'(rs2_sel);
    clr = model_xfer_rd();
    b1  = (r1 != 0) && m_busy[r1];
    b2  = (r2 != 0) && m_busy[r2];
`ifdef WB_EARLY_RELEASE_EN
    if (clr != 0 && r1 == clr) b1 = 1'b0;
    if (clr != 0 && r2 == clr) b2 = 1'b0;
`endif
    return b1 || b2;
  endfunction

  function automatic logic [31:0] model_busy_word();
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic model_reset();
    m_last   = 1;
    m_rd_w   = 1'b0;
    m_rd_sel = 0;
    m_rd_in  = 32'd0;
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
  endtask

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_clock();
    int w;
    int rd;
    w  = model_winner();
    rd = model_xfer_rd();
    m_rd_w = 1'b0;
    if (w >= 0) begin
      m_last = w;
      if (rd != 0) begin
        m_rd_w   = 1'b1;
        m_rd_sel = rd;
        m_rd_in  = (w == 0) ? alu_data : lsu_data;
        m_busy[rd] = 1'b0;
      end
    end
    if (issue_valid && issue_rd != 5'd0) m_busy[int'(issue_rd)] = 1'b1;
  endtask

  task automatic clear_inputs();
    issue_valid = 1'b0;
    issue_rd    = 5'd0;
    rs1_sel     = 5'd0;
    rs2_sel     = 5'd0;
    alu_valid   = 1'b0;
    alu_rd      = 5'd0;
    alu_data    = 32'd0;
    lsu_valid   = 1'b0;
    lsu_rd      = 5'd0;
    lsu_data    = 32'd0;
  endtask

  // Reset DUT and model; returns 1 time unit after a rising edge.
  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst       = 1'b1;
    alu_valid = 1'b1;
    lsu_valid = 1'b1;
    alu_rd    = 5'd3;
    lsu_rd    = 5'd4;
    #2;
    checks++; if (rd_w !== 1'b0) begin failures++; $display("FAIL reset_rd_w got=%b exp=0", rd_w); end
    checks++; if (rd_sel !== 5'd0) begin failures++; $display("FAIL reset_rd_sel got=%0d exp=0", rd_sel); end
    checks++; if (rd_in !== 32'd0) begin failures++; $display("FAIL reset_rd_in got=%h exp=0", rd_in); end
    checks++; if (busy !== 32'd0) begin failures++; $display("FAIL reset_busy got=%h exp=0", busy); end
    checks++; if (alu_ready !== 1'b0 || lsu_ready !== 1'b0) begin
      failures++; $display("FAIL reset_ready got=%b%b exp=00", alu_ready, lsu_ready);
    end
    do_reset();
  endtask

  task automatic test_single_alu();
    do_reset();
    alu_valid = 1'b1;
    alu_rd    = 5'd5;
    alu_data  = 32'hDEADBEEF;
    #2;
    checks++; if (alu_ready !== 1'b1 || lsu_ready !== 1'b0) begin
      failures++; $display("FAIL single_ready got=%b%b exp=10", alu_ready, lsu_ready);
    end
    checks++; if (rd_w !== 1'b0) begin failures++; $display("FAIL single_no_early_write got=%b exp=0", rd_w); end
    tick();
    alu_valid = 1'b0;
    alu_data  = 32'h0;
    checks++; if (rd_w !== 1'b1 || rd_sel !== 5'd5 || rd_in !== 32'hDEADBEEF) begin
      failures++; $display("FAIL single_write got=%b/%0d/%h exp=1/5/deadbeef", rd_w, rd_sel, rd_in);
    end
    tick();
    checks++; if (rd_w !== 1'b0 || rd_sel !== 5'd5 || rd_in !== 32'hDEADBEEF) begin
      failures++; $display("FAIL single_hold got=%b/%0d/%h exp=0/5/deadbeef", rd_w, rd_sel, rd_in);
    end
  endtask

  task automatic test_round_robin();
    int          alu_n;
    int          lsu_n;
    bit          exp_alu;
    logic [4:0]  exp_sel;
    logic [31:0] exp_data;
    do_reset();
    alu_n = 0;
    lsu_n = 0;
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1'b1;
      lsu_valid = 1'b1;
      alu_rd    = 5'(2 * alu_n + 1);
      lsu_rd    = 5'(2 * lsu_n + 2 + 16);
      alu_data  = 32'hA000_0000 + 32'(alu_n);
      lsu_data  = 32'hB000_0000 + 32'(lsu_n);
      exp_alu   = ((i % 2) == 0);
      exp_sel   = exp_alu ? alu_rd : lsu_rd;
      exp_data  = exp_alu ? alu_data : lsu_data;
      #2;
      checks++; if (alu_ready !== exp_alu || lsu_ready !== !exp_alu) begin
        failures++; $display("FAIL rr_grant cycle=%0d got=%b%b exp=%b%b", i, alu_ready, lsu_ready, exp_alu, !exp_alu);
      end
      tick();
      checks++; if (rd_w !== 1'b1 || rd_sel !== exp_sel || rd_in !== exp_data) begin
        failures++; $display("FAIL rr_write cycle=%0d got=%b/%0d/%h exp=1/%0d/%h", i, rd_w, rd_sel, rd_in, exp_sel, exp_data);
      end
      if (exp_alu) alu_n++; else lsu_n++;
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_hazard();
    do_reset();
    issue_valid = 1'b1;
    issue_rd    = 5'd7;
    tick();
    issue_valid = 1'b0;
    issue_rd    = 5'd0;
    rs1_sel     = 5'd7;
    #1;
    checks++; if (busy !== 32'h0000_0080 || hazard !== 1'b1) begin
      failures++; $display("FAIL hazard_set got busy=%h hz=%b exp busy=00000080 hz=1", busy, hazard);
    end
    lsu_valid = 1'b1;
    lsu_rd    = 5'd7;
    lsu_data  = $urandom;
    #1;
`ifdef WB_EARLY_RELEASE_EN
    checks++; if (lsu_ready !== 1'b1 || hazard !== 1'b0) begin
      failures++; $display("FAIL hazard_xfer_cycle got rdy=%b hz=%b exp rdy=1 hz=0", lsu_ready, hazard);
    end
`else
    checks++; if (lsu_ready !== 1'b1 || hazard !== 1'b1) begin
      failures++; $display("FAIL hazard_xfer_cycle got rdy=%b hz=%b exp rdy=1 hz=1", lsu_ready, hazard);
    end
`endif
    tick();
    lsu_valid = 1'b0;
    #1;
    checks++; if (busy !== 32'd0 || hazard !== 1'b0 || rd_w !== 1'b1 || rd_sel !== 5'd7) begin
      failures++; $display("FAIL hazard_clear got busy=%h hz=%b w=%b sel=%0d exp 0/0/1/7", busy, hazard, rd_w, rd_sel);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_set_wins();
    do_reset();
    issue_valid = 1'b1;
    issue_rd    = 5'd9;
    tick();
    alu_valid = 1'b1;
    alu_rd    = 5'd9;
    alu_data  = 32'h1234_5678;
    #1;
    checks++; if (alu_ready !== 1'b1 || busy !== 32'h0000_0200) begin
      failures++; $display("FAIL setwins_pre got rdy=%b busy=%h exp 1/00000200", alu_ready, busy);
    end
    tick();
    clear_inputs();
    checks++; if (busy !== 32'h0000_0200 || rd_w !== 1'b1 || rd_sel !== 5'd9 || rd_in !== 32'h1234_5678) begin
      failures++; $display("FAIL setwins_post got busy=%h w=%b sel=%0d in=%h exp 00000200/1/9/12345678", busy, rd_w, rd_sel, rd_in);
    end
    tick();
  endtask

  task automatic test_rd_zero();
    do_reset();
    alu_valid   = 1'b1;
    alu_rd      = 5'd0;
    alu_data    = 32'hFFFF_0000;
    issue_valid = 1'b1;
    issue_rd    = 5'd0;
    #1;
    checks++; if (alu_ready !== 1'b1 || hazard !== 1'b0) begin
      failures++; $display("FAIL rdzero_ready got rdy=%b hz=%b exp 1/0", alu_ready, hazard);
    end
    tick();
    // ALU just won, so a contested cycle must now go to the LSU.
    issue_valid = 1'b0;
    lsu_valid   = 1'b1;
    lsu_rd      = 5'd0;
    #1;
    checks++; if (rd_w !== 1'b0 || busy !== 32'd0) begin
      failures++; $display("FAIL rdzero_nowrite got w=%b busy=%h exp 0/0", rd_w, busy);
    end
    checks++; if (alu_ready !== 1'b0 || lsu_ready !== 1'b1) begin
      failures++; $display("FAIL rdzero_rr got=%b%b exp=01", alu_ready, lsu_ready);
    end
    tick();
    clear_inputs();
    checks++; if (rd_w !== 1'b0 || busy !== 32'd0) begin
      failures++; $display("FAIL rdzero_nowrite2 got w=%b busy=%h exp 0/0", rd_w, busy);
    end
    tick();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    for (int r = 8; r < 12; r++) begin
      issue_valid = 1'b1;
      issue_rd    = 5'(r);
      tick();
    end
    issue_valid = 1'b0;
    issue_rd    = 5'd0;
    checks++; if (busy !== 32'h0000_0F00) begin
      failures++; $display("FAIL midrst_busy_pre got=%h exp=00000f00", busy);
    end
    alu_valid = 1'b1;
    alu_rd    = 5'd12;
    alu_data  = 32'h5555_AAAA;
    #1;
    rst = 1'b1;
    #1;
    checks++; if (busy !== 32'd0 || rd_w !== 1'b0 || alu_ready !== 1'b0 || lsu_ready !== 1'b0) begin
      failures++; $display("FAIL midrst_async got busy=%h w=%b rdy=%b%b exp 0/0/00", busy, rd_w, alu_ready, lsu_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b0;
    alu_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (rd_w !== 1'b0 || busy !== 32'd0 || rd_sel !== 5'd0) begin
        failures++; $display("FAIL midrst_after cyc=%0d got w=%b busy=%h sel=%0d exp 0/0/0", k, rd_w, busy, rd_sel);
      end
    end
    clear_inputs();
  endtask

  task automatic test_random();
    bit alu_hold;
    bit lsu_hold;
    int w;
    do_reset();
    alu_hold = 1'b0;
    lsu_hold = 1'b0;
    for (int c = 0; c < 400; c++) begin
      // A source left waiting must keep its request unchanged.
      if (!alu_hold) begin
        alu_valid = ($urandom_range(0, 2) != 0);
        alu_rd    = 5'($urandom_range(0, 15));
        alu_data  = $urandom;
      end
      if (!lsu_hold) begin
        lsu_valid = ($urandom_range(0, 2) != 0);
        lsu_rd    = 5'($urandom_range(0, 15));
        lsu_data  = $urandom;
      end
      issue_valid = ($urandom_range(0, 1) != 0);
      issue_rd    = 5'($urandom_range(0, 15));
      rs1_sel     = 5'($urandom_range(0, 15));
      rs2_sel     = 5'($urandom_range(0, 15));
      #2;
      w = model_winner();
      checks++; if (alu_ready !== (w == 0) || lsu_ready !== (w == 1)) begin
        failures++; $display("FAIL rand_ready cyc=%0d got=%b%b exp=%b%b", c, alu_ready, lsu_ready, (w == 0), (w == 1));
      end
      checks++; if (hazard !== model_hazard()) begin
        failures++; $display("FAIL rand_hazard cyc=%0d got=%b exp=%b", c, hazard, model_hazard());
      end
      alu_hold = alu_valid && (w != 0);
      lsu_hold = lsu_valid && (w != 1);
      @(posedge clk);
      #1;
      model_clock();
      checks++; if (rd_w !== m_rd_w || int'(rd_sel) != m_rd_sel || rd_in !== m_rd_in) begin
        failures++; $display("FAIL rand_write cyc=%0d got=%b/%0d/%h exp=%b/%0d/%h", c, rd_w, rd_sel, rd_in, m_rd_w, m_rd_sel, m_rd_in);
      end
      checks++; if (busy !== model_busy_word()) begin
        failures++; $display("FAIL rand_busy cyc=%0d got=%h exp=%h", c, busy, model_busy_word());
      end
    end
    clear_inputs();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    model_reset();
    clear_inputs();
    test_reset();
    test_single_alu();
    test_round_robin();
    test_hazard();
    test_set_wins();
    test_rd_zero();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
